izh_run_sequencer: RTL
======================

Name: izh_run_sequencer

Overview:
Controller that configures and sequences one Izhikevich neuron system for a single experiment run.
- On start, it latches four 12-bit signed parameters (a, b, c, d) and shifts them serially into the neuron's data loader under load_mode.
- It then waits for params_ready and enables the neuron with a constant stimulus for a programmed number of cycles.
- It counts output spikes during the run and reports done or error.
- It sits between top-level control pins and the neuron system's input_enable / load_mode / serial_data / stimulus_in / params_ready / spike_out / debug_state pins.

Parameters:
- PARAM_W, 12, width of each neuron parameter.
- NUM_PARAMS, 4, parameters per frame (a, b, c, d).
- TIMEOUT, 255, maximum WAIT_RDY cycles before error (≥1).
- RUN_W, 16, width of the run-length counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; ignored unless state is IDLE, DONE or ERROR.
- abort  in  1  forces return to IDLE.
- param_a/param_b/param_c/param_d  in  PARAM_W each  signed neuron parameters.
- run_cycles  in  RUN_W  number of RUN cycles.
- stim_level  in  8  stimulus value applied during RUN.
- load_mode  out  1  to neuron loader; high while shifting.
- serial_data  out  1  parameter bitstream.
- input_enable  out  1  neuron enable; high only in RUN.
- stimulus_out  out  8  to neuron stimulus_in; stim_level in RUN, else 0.
- params_ready  in  1  from neuron loader.
- spike_in  in  1  neuron spike_out.
- spike_count  out  8  spikes counted in the current/last run, saturating.
- busy  out  1  high in LOAD, WAIT_RDY, RUN.
- done  out  1  one-cycle pulse on run completion.
- error  out  1  high in ERROR.
- state_out  out  3  encoded state, to debug_state pins.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; shift register, counters and spike edge register 0.
- States and encoding: IDLE=0, LOAD=1, WAIT_RDY=2, RUN=3, DONE=4, ERROR=5. Codes 6 and 7 are illegal and go to IDLE.
- IDLE/DONE/ERROR with start=1 at edge N:
  - Latch {param_a, param_b, param_c, param_d} into a 48-bit shift register, a in the MSBs.
  - Latch run_cycles and stim_level.
  - Clear spike_count.
  - Enter LOAD at N.
- LOAD: load_mode=1; serial_data = shift register MSB (a[11] in the first cycle, d[0] in the 48th). Shift left once per cycle. After exactly PARAM_W*NUM_PARAMS=48 cycles, enter WAIT_RDY.
- WAIT_RDY:
  - load_mode=0; the timeout counter increments each cycle.
  - params_ready=1 → RUN next edge.
  - If counter reaches TIMEOUT without ready → ERROR.
  - If params_ready is already high on the first WAIT_RDY cycle, go to RUN (one-cycle minimum).
- RUN:
  - input_enable=1; stimulus_out=latched stim_level; run counter decrements from run_cycles.
  - Enters DONE after exactly run_cycles RUN cycles.
  - run_cycles=0 → WAIT_RDY goes directly to DONE; input_enable never asserts.
- Spike counting: rising edge of spike_in (registered previous value) while in RUN increments spike_count, saturating at 255. Edges outside RUN are ignored. spike_count holds after the run until the next start.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is accepted, with priority over the return to IDLE.
- ERROR: error=1; sticky until start (→LOAD) or abort (→IDLE).
- abort=1 in any state:
  - Next state IDLE; load_mode, input_enable, stimulus_out drop at that edge.
  - spike_count holds.
  - abort has priority over start and over all transitions.
- start while busy is ignored; latched values are unchanged.
- All outputs are registered; no combinational input→output paths.

Decomposition:
- Shared package izh_pkg holds:
  - state encoding constants (IDLE..ERROR);
  - PARAM_W=12 and NUM_PARAMS=4;
  - FRAME_BITS=48 (single source of truth for the loader frame length).
- One sub-module: izh_param_serializer, a 48-bit parallel-load shift register with bit counter. Inputs: load, shift. Outputs: bit, last.

Test Plan:
- Bitstream: a=0x001, b=0x002, c=0xF9C (−100), d=0x008; start → load_mode high exactly 48 cycles; serial_data sequence 000000000001 000000000010 111110011100 000000001000.
- Nominal run: params_ready asserted 3 cycles after LOAD ends; run_cycles=10, stim_level=0x40 → input_enable high exactly 10 cycles with stimulus_out=0x40; done pulses once; state_out returns to 0.
- Spike count: 5 spike_in pulses inside RUN and 2 outside → spike_count=5. 300 pulses in a long run → spike_count=255.
- Timeout: params_ready held 0 → ERROR after 255 WAIT_RDY cycles, error=1. A subsequent start restarts LOAD and clears error.
- Abort mid-LOAD (cycle 20) and mid-RUN → IDLE next edge; load_mode, input_enable, stimulus_out = 0; a later start reproduces the full 48-bit frame.
- Edge cases: run_cycles=0 → done with no input_enable; start during RUN ignored; async reset mid-RUN clears all outputs immediately.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared constants and state encoding for the Izhikevich run sequencer.
// FRAME_BITS is the one place the loader frame length is defined.
package izh_pkg;

  localparam int PARAM_W    = 12;
  localparam int NUM_PARAMS = 4;
  localparam int FRAME_BITS = PARAM_W * NUM_PARAMS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == ST_LOAD) || (s == ST_WAIT_RDY) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/izh_param_serializer.sv
// Parallel-load shift register that streams a parameter frame MSB first.
// last_o flags the final bit of the frame.
module izh_param_serializer
  import izh_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  bit_o,
  output logic                  last_o
);

  localparam int CW = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (load) begin
      sr_d  = frame;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o  = sr_q[FRAME_BITS-1];
  assign last_o = (cnt_q == CW'(FRAME_BITS - 1));

endmodule

// File: rtl/izh_run_sequencer.sv
// Configures one Izhikevich neuron, runs it with a constant stimulus for a
// programmed number of cycles and counts its spikes.
module izh_run_sequencer
  import izh_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int RUN_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [PARAM_W-1:0] param_a,
  input  logic signed [PARAM_W-1:0] param_b,
  input  logic signed [PARAM_W-1:0] param_c,
  input  logic signed [PARAM_W-1:0] param_d,
  input  logic [RUN_W-1:0]          run_cycles,
  input  logic [7:0]                stim_level,
  output logic                      load_mode,
  output logic                      serial_data,
  output logic                      input_enable,
  output logic [7:0]                stimulus_out,
  input  logic                      params_ready,
  input  logic                      spike_in,
  output logic [7:0]                spike_count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [2:0]                state_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] len_q, len_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       stim_q, stim_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             spk_q;
  logic             load_q, load_d;
  logic             ien_q, ien_d;
  logic [7:0]       sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic idle_like, accept, rise;
  logic ser_bit, ser_last;
  logic [FRAME_BITS-1:0] frame;

  assign frame = {param_a, param_b, param_c, param_d};

  assign idle_like = (state_q == ST_IDLE) ||
                     (state_q == ST_DONE) ||
                     (state_q == ST_ERROR);
  assign accept = start & idle_like & ~abort;
  // An aborted cycle never bumps the count.
  assign rise = spike_in & ~spk_q & (state_q == ST_RUN) & ~abort;

  izh_param_serializer u_ser (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (abort),
    .load   (accept),
    .shift  (state_q == ST_LOAD),
    .frame  (frame),
    .bit_o  (ser_bit),
    .last_o (ser_last)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    if (rise && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (ser_last) begin
          state_d = ST_WAIT_RDY;
          tmo_d   = '0;
        end
      end
      ST_WAIT_RDY: begin
        if (params_ready) begin
          state_d = (len_q == '0) ? ST_DONE : ST_RUN;
          run_d   = len_q;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (run_q <= RUN_W'(1)) state_d = ST_DONE;
        else run_d = run_q - RUN_W'(1);
      end
      ST_DONE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_ERROR: if (start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      len_d  = run_cycles;
      stim_d = stim_level;
      cnt_d  = '0;
    end
    if (abort) state_d = ST_IDLE;
    load_d = (state_d == ST_LOAD);
    ien_d  = (state_d == ST_RUN);
    sout_d = (state_d == ST_RUN) ? stim_d : 8'd0;
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      run_q   <= '0;
      tmo_q   <= '0;
      stim_q  <= '0;
      cnt_q   <= '0;
      spk_q   <= 1'b0;
      load_q  <= 1'b0;
      ien_q   <= 1'b0;
      sout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      spk_q   <= spike_in;
      load_q  <= load_d;
      ien_q   <= ien_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign load_mode    = load_q;
  assign serial_data  = ser_bit;
  assign input_enable = ien_q;
  assign stimulus_out = sout_q;
  assign spike_count  = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign state_out    = state_q;

endmodule
